// File: rtl/assert_monitor_array_if.sv
// Assertion monitor bus.
// Groups the monitor controls (arm, per-channel cond/en, clear) and the
// recorded failure state (sticky flags, counts, first-failure record, timestamp).
//   master : drives arm/cond/en/clear, observes results
//   slave  : the monitor array itself
interface assert_monitor_array_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int TS_W   = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                    arm;
  logic [NUM_CH-1:0]       cond;
  logic [NUM_CH-1:0]       en;
  logic                    clear;
  logic [NUM_CH-1:0]       fail_flags;
  logic                    fail_any;
  logic [NUM_CH*CNT_W-1:0] fail_cnt;
  logic                    first_valid;
  logic [CH_W-1:0]         first_ch;
  logic [TS_W-1:0]         first_ts;
  logic [TS_W-1:0]         cur_ts;

  modport master (
    output arm, cond, en, clear,
    input  fail_flags, fail_any, fail_cnt, first_valid, first_ch, first_ts, cur_ts
  );

  modport slave (
    input  arm, cond, en, clear,
    output fail_flags, fail_any, fail_cnt, first_valid, first_ch, first_ts, cur_ts
  );
endinterface

// File: rtl/assert_monitor_array.sv
// Array of assertion monitors with grace filtering, sticky flags,
// saturating per-channel event counts and a first-failure record.
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : assert_monitor_array_if.slave (arm/cond/en/clear in, failure state out)
//
// state    | meaning
// IDLE     | no failure recorded since reset/clear
// CAPTURED | first-failure record valid and frozen until clear
module assert_monitor_array #(
  parameter int NUM_CH = 4,
  parameter int GRACE  = 0,
  parameter int CNT_W  = 8,
  parameter int TS_W   = 32,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  assert_monitor_array_if.slave bus
);
  typedef enum logic {IDLE, CAPTURED} state_t;

  state_t                  state_q;
  logic [NUM_CH-1:0]       viol;
  logic [NUM_CH-1:0]       evt;
  logic                    any_evt;
  logic [CH_W-1:0]         evt_ch;
  logic [7:0]              run_q [NUM_CH];
  logic [CNT_W-1:0]        cnt_q [NUM_CH];
  logic [NUM_CH-1:0]       flags_q;
  logic [TS_W-1:0]         ts_q;
  logic                    first_valid_q;
  logic [CH_W-1:0]         first_ch_q;
  logic [TS_W-1:0]         first_ts_q;
  logic [NUM_CH*CNT_W-1:0] cnt_packed;

  assign viol    = {NUM_CH{bus.arm}} & bus.en & ~bus.cond;
  assign any_evt = |evt;

  // Descending scan so the lowest violating channel wins.
  always_comb begin
    evt    = '0;
    evt_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      evt[i] = viol[i] && (run_q[i] == 8'(GRACE));
      if (evt[i]) evt_ch = CH_W'(i);
    end
  end

  // Run counters hold at GRACE so sustained violation keeps firing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) run_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!viol[i])                      run_q[i] <= '0;
        else if (run_q[i] != 8'(GRACE))    run_q[i] <= run_q[i] + 8'd1;
      end
    end
  end

  // An event in the same cycle as clear wins: flag set, count restarts at 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (evt[i]) begin
          flags_q[i] <= 1'b1;
          if (bus.clear)            cnt_q[i] <= CNT_W'(1);
          else if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (bus.clear) begin
          flags_q[i] <= 1'b0;
          cnt_q[i]   <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_ts_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_evt) begin
            state_q       <= CAPTURED;
            first_valid_q <= 1'b1;
            first_ch_q    <= evt_ch;
            first_ts_q    <= ts_q;
          end
        end
        CAPTURED: begin
          if (bus.clear) begin
            if (any_evt) begin
              first_ch_q <= evt_ch;
              first_ts_q <= ts_q;
            end else begin
              state_q       <= IDLE;
              first_valid_q <= 1'b0;
              first_ch_q    <= '0;
              first_ts_q    <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_packed = '0;
    for (int i = 0; i < NUM_CH; i++) cnt_packed[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign bus.fail_flags  = flags_q;
  assign bus.fail_any    = |flags_q;
  assign bus.fail_cnt    = cnt_packed;
  assign bus.first_valid = first_valid_q;
  assign bus.first_ch    = first_ch_q;
  assign bus.first_ts    = first_ts_q;
  assign bus.cur_ts      = ts_q;

`ifndef SYNTHESIS
`ifndef PRINTF_COND
`define PRINTF_COND 1'b1
`endif
  always @(posedge clock) begin
    if (`PRINTF_COND && !reset) begin
      for (int i = 0; i < NUM_CH; i++)
        if (evt[i]) $display("assert_monitor_array: event ch=%0d ts=%0d", i, ts_q);
    end
  end
`endif
endmodule

// File: tb/tb_assert_monitor_array.sv
module tb_assert_monitor_array;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  // dut0: GRACE=0, 4-bit counters; dut2: GRACE=2, 8-bit counters. Shared stimulus.
  assert_monitor_array_if #(.NUM_CH(4), .CNT_W(4), .TS_W(32)) if0 ();
  assert_monitor_array_if #(.NUM_CH(4), .CNT_W(8), .TS_W(32)) if2 ();

  assert_monitor_array #(.NUM_CH(4), .GRACE(0), .CNT_W(4), .TS_W(32)) dut0 (
    .clock(clock), .reset(reset), .bus(if0.slave));
  assert_monitor_array #(.NUM_CH(4), .GRACE(2), .CNT_W(8), .TS_W(32)) dut2 (
    .clock(clock), .reset(reset), .bus(if2.slave));

  task automatic drive(input logic a, input logic [3:0] e, input logic [3:0] c, input logic clr);
    if0.arm = a; if0.en = e; if0.cond = c; if0.clear = clr;
    if2.arm = a; if2.en = e; if2.cond = c; if2.clear = clr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called 1 time unit after an edge; reset pulse ends well before the next edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'hF, 4'h0, 1'b0);
    tick(); tick();
    if (if0.fail_flags !== 4'h0) begin n_fail++; $display("FAIL rst_flags: got %h want 0", if0.fail_flags); end
    n_checks++;
    if (if0.fail_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", if0.fail_cnt); end
    n_checks++;
    if (if0.cur_ts !== 32'd0 || if0.first_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_ts_valid: got ts=%0d valid=%b want 0/0", if0.cur_ts, if0.first_valid); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    reset = 1'b0;
    tick();
    if (if0.cur_ts !== 32'd1) begin n_fail++; $display("FAIL rst_first_edge_ts: got %0d want 1", if0.cur_ts); end
    n_checks++;
  endtask

  task automatic test_single_event();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    do_reset();
    repeat (5) tick();
    if (if0.cur_ts !== 32'd5) begin n_fail++; $display("FAIL single_ts_pre: got %0d want 5", if0.cur_ts); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hB, 1'b0);
    tick();
    if (if0.fail_flags !== 4'h4) begin n_fail++; $display("FAIL single_flags: got %h want 4", if0.fail_flags); end
    n_checks++;
    if (if0.fail_cnt !== 16'h0100) begin n_fail++; $display("FAIL single_cnt: got %h want 0100", if0.fail_cnt); end
    n_checks++;
    if (if0.first_ch !== 2'd2 || if0.first_ts !== 32'd5 || if0.first_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_record: got ch=%0d ts=%0d v=%b want 2/5/1", if0.first_ch, if0.first_ts, if0.first_valid); end
    n_checks++;
    if (if0.fail_any !== 1'b1) begin n_fail++; $display("FAIL single_any: got %b want 1", if0.fail_any); end
    n_checks++;
    if (if2.fail_flags !== 4'h0) begin n_fail++; $display("FAIL single_grace2_flags: got %h want 0", if2.fail_flags); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    if (if0.fail_flags !== 4'h4) begin n_fail++; $display("FAIL single_sticky: got %h want 4", if0.fail_flags); end
    n_checks++;
  endtask

  task automatic test_grace();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    do_reset();
    drive(1'b1, 4'hF, 4'hE, 1'b0);
    tick(); tick();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    if (if2.fail_flags !== 4'h0 || if2.fail_cnt[7:0] !== 8'd0) begin
      n_fail++; $display("FAIL grace_short: got flags=%h cnt=%0d want 0/0", if2.fail_flags, if2.fail_cnt[7:0]); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hE, 1'b0);
    tick(); tick();
    if (if2.fail_flags !== 4'h0) begin n_fail++; $display("FAIL grace_pre_threshold: got %h want 0", if2.fail_flags); end
    n_checks++;
    tick();
    if (if2.fail_flags !== 4'h1 || if2.fail_cnt[7:0] !== 8'd1 || if2.first_ts !== 32'd5) begin
      n_fail++; $display("FAIL grace_first_event: got flags=%h cnt=%0d ts=%0d want 1/1/5",
                         if2.fail_flags, if2.fail_cnt[7:0], if2.first_ts); end
    n_checks++;
    tick();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    if (if2.fail_cnt[7:0] !== 8'd2) begin n_fail++; $display("FAIL grace_two_events: got %0d want 2", if2.fail_cnt[7:0]); end
    n_checks++;
  endtask

  task automatic test_saturate();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    do_reset();
    drive(1'b1, 4'hF, 4'hD, 1'b0);
    repeat (15) tick();
    if (if0.fail_cnt[7:4] !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", if0.fail_cnt[7:4]); end
    n_checks++;
    repeat (5) tick();
    if (if0.fail_cnt[7:4] !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", if0.fail_cnt[7:4]); end
    n_checks++;
    if (if0.fail_cnt[3:0] !== 4'd0 || if0.fail_cnt[15:8] !== 8'd0) begin
      n_fail++; $display("FAIL sat_other_ch: got %h want 0 outside ch1", if0.fail_cnt); end
    n_checks++;
    if (if2.fail_cnt[15:8] !== 8'd18) begin n_fail++; $display("FAIL sat_grace2_cnt: got %0d want 18", if2.fail_cnt[15:8]); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
  endtask

  task automatic test_first_priority();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    do_reset();
    tick(); tick();
    drive(1'b1, 4'hF, 4'h5, 1'b0);
    tick();
    if (if0.first_ch !== 2'd1 || if0.first_ts !== 32'd2 || if0.fail_flags !== 4'hA) begin
      n_fail++; $display("FAIL prio_same_cycle: got ch=%0d ts=%0d flags=%h want 1/2/a",
                         if0.first_ch, if0.first_ts, if0.fail_flags); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    drive(1'b1, 4'hF, 4'hE, 1'b0);
    tick();
    if (if0.first_ch !== 2'd1 || if0.first_ts !== 32'd2 || if0.fail_flags !== 4'hB) begin
      n_fail++; $display("FAIL prio_frozen: got ch=%0d ts=%0d flags=%h want 1/2/b",
                         if0.first_ch, if0.first_ts, if0.fail_flags); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
  endtask

  task automatic test_clear();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    do_reset();
    drive(1'b1, 4'hF, 4'hA, 1'b0);
    tick();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    tick(); tick();
    drive(1'b1, 4'hF, 4'hB, 1'b1);
    tick();
    if (if0.fail_flags !== 4'h4 || if0.fail_cnt !== 16'h0100) begin
      n_fail++; $display("FAIL clr_evt_wins: got flags=%h cnt=%h want 4/0100", if0.fail_flags, if0.fail_cnt); end
    n_checks++;
    if (if0.first_valid !== 1'b1 || if0.first_ch !== 2'd2 || if0.first_ts !== 32'd3) begin
      n_fail++; $display("FAIL clr_recapture: got v=%b ch=%0d ts=%0d want 1/2/3",
                         if0.first_valid, if0.first_ch, if0.first_ts); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    tick();
    if (if0.fail_flags !== 4'h0 || if0.fail_any !== 1'b0 || if0.fail_cnt !== 16'h0) begin
      n_fail++; $display("FAIL clr_plain: got flags=%h any=%b cnt=%h want 0/0/0", if0.fail_flags, if0.fail_any, if0.fail_cnt); end
    n_checks++;
    if (if0.first_valid !== 1'b0 || if0.first_ts !== 32'd0 || if0.cur_ts !== 32'd6) begin
      n_fail++; $display("FAIL clr_record_ts: got v=%b fts=%0d cur=%0d want 0/0/6", if0.first_valid, if0.first_ts, if0.cur_ts); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    do_reset();
    drive(1'b1, 4'hF, 4'hE, 1'b0);
    tick(); tick();
    if (if0.fail_flags !== 4'h1) begin n_fail++; $display("FAIL mid_pre: got %h want 1", if0.fail_flags); end
    n_checks++;
    reset = 1'b1;
    #1;
    if (if0.fail_flags !== 4'h0 || if0.fail_cnt !== 16'h0 || if0.fail_any !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_flags: got flags=%h cnt=%h any=%b want 0", if0.fail_flags, if0.fail_cnt, if0.fail_any); end
    n_checks++;
    if (if0.first_valid !== 1'b0 || if0.first_ts !== 32'd0 || if0.cur_ts !== 32'd0) begin
      n_fail++; $display("FAIL mid_async_record: got v=%b fts=%0d cur=%0d want 0", if0.first_valid, if0.first_ts, if0.cur_ts); end
    n_checks++;
    reset = 1'b0;
    tick(); tick();
    if (if2.fail_flags !== 4'h0) begin n_fail++; $display("FAIL mid_run_discarded: got %h want 0", if2.fail_flags); end
    n_checks++;
    tick();
    if (if2.fail_flags !== 4'h1) begin n_fail++; $display("FAIL mid_fresh_event: got %h want 1", if2.fail_flags); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
  endtask

  task automatic test_masked();
    drive(1'b1, 4'hF, 4'hF, 1'b0);
    do_reset();
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    repeat (5) tick();
    if (if0.fail_flags !== 4'h0 || if0.fail_any !== 1'b0) begin
      n_fail++; $display("FAIL mask_en: got flags=%h any=%b want 0/0", if0.fail_flags, if0.fail_any); end
    n_checks++;
    drive(1'b0, 4'hF, 4'h0, 1'b0);
    repeat (5) tick();
    if (if0.fail_flags !== 4'h0 || if0.first_valid !== 1'b0) begin
      n_fail++; $display("FAIL mask_arm: got flags=%h v=%b want 0/0", if0.fail_flags, if0.first_valid); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hE, 1'b0);
    tick(); tick();
    drive(1'b0, 4'hF, 4'hE, 1'b0);
    tick();
    drive(1'b1, 4'hF, 4'hE, 1'b0);
    tick(); tick();
    if (if2.fail_flags !== 4'h0) begin n_fail++; $display("FAIL disarm_resets_run: got %h want 0", if2.fail_flags); end
    n_checks++;
    tick();
    if (if2.fail_flags !== 4'h1) begin n_fail++; $display("FAIL rearm_event: got %h want 1", if2.fail_flags); end
    n_checks++;
    drive(1'b1, 4'hF, 4'hF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_grace();
    test_saturate();
    test_first_priority();
    test_clear();
    test_reset_midrun();
    test_masked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
